// File: rtl/m_game_round_ctrl.sv
// Multi-round controller for the shrinking-frame target game: round timer,
// LFSR-driven frame shrink, stop/timeout capture and clamped score tracking.
module m_game_round_ctrl #(
    parameter int unsigned CLK_HZ      = 40000000,
    parameter int unsigned STEP_DIV    = 500000,
    parameter int unsigned ROUND_SEC   = 30,
    parameter int unsigned ROUNDS      = 3,
    parameter int unsigned W           = 11,
    parameter int unsigned MAX_HALF_W  = 400,
    parameter int unsigned MAX_HALF_H  = 300,
    parameter int unsigned TGT_HALF_W  = 20,
    parameter int unsigned TGT_HALF_H  = 15,
    parameter int unsigned SW          = 32,
    parameter int unsigned SCORE_BASE  = 500000,
    parameter int unsigned SEC_PENALTY = 15000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [3:0]    i_rand,
    output logic [W-1:0]  o_half_w,
    output logic [W-1:0]  o_half_h,
    output logic [7:0]    o_seconds,
    output logic [3:0]    o_round,
    output logic [SW-1:0] o_score,
    output logic [SW-1:0] o_best,
    output logic          o_score_valid,
    output logic          o_running,
    output logic          o_game_over
);

    localparam int unsigned SEC_CW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned STEP_CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [SEC_CW-1:0]  SEC_LAST  = SEC_CW'(CLK_HZ - 1);
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);
    localparam logic [7:0]         SEC_LIMIT = 8'(ROUND_SEC);
    localparam logic [3:0]         RND_LAST  = 4'(ROUNDS);
    localparam logic [W-1:0]       MAX_W     = W'(MAX_HALF_W);
    localparam logic [W-1:0]       MAX_H     = W'(MAX_HALF_H);
    localparam logic [W-1:0]       TGT_W     = W'(TGT_HALF_W);
    localparam logic [W-1:0]       TGT_H     = W'(TGT_HALF_H);
    localparam logic [SW-1:0]      BASE      = SW'(SCORE_BASE);
    localparam logic [SW-1:0]      PEN       = SW'(SEC_PENALTY);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CALC1,
        CALC2,
        HOLD,
        DONE
    } state_t;

    state_t state, state_next;

    logic                start_q, stop_q;
    logic                start_edge, stop_edge;
    logic [SEC_CW-1:0]   sec_cnt;
    logic [STEP_CW-1:0]  step_cnt;
    logic [SW-1:0]       area, penalty;
    logic                sec_wrap, step_tick, run_exit, round_start;
    logic [7:0]          seconds_next;
    logic signed [SW:0]  diff;
    logic [SW-1:0]       score_calc;

    // Saturating shrink; a frame already inside the target snaps back to max.
    function automatic logic [W-1:0] shrink(input logic [W-1:0] cur,
                                            input logic [3:0]   r,
                                            input logic [W-1:0] tgt,
                                            input logic [W-1:0] max);
        if (cur > tgt)
            return (cur >= W'(r)) ? cur - W'(r) : '0;
        else
            return max;
    endfunction

    assign start_edge  = i_start & ~start_q;
    assign stop_edge   = i_stop & ~stop_q;
    assign o_running   = (state == RUN);
    assign o_game_over = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        round_start  = 1'b0;
        sec_wrap     = (sec_cnt == SEC_LAST);
        step_tick    = (step_cnt == STEP_LAST);
        seconds_next = o_seconds;
        if (sec_wrap && o_seconds != 8'hFF)
            seconds_next = o_seconds + 8'd1;
        run_exit     = stop_edge || (sec_wrap && seconds_next == SEC_LIMIT);

        diff = $signed({1'b0, BASE}) - $signed({1'b0, area}) - $signed({1'b0, penalty});
        score_calc = diff[SW] ? '0 : diff[SW-1:0];

        case (state)
            IDLE, HOLD, DONE: begin
                if (start_edge) begin
                    state_next  = RUN;
                    round_start = 1'b1;
                end
            end
            RUN:     if (run_exit) state_next = CALC1;
            CALC1:   state_next = CALC2;
            CALC2:   state_next = (o_round == RND_LAST) ? DONE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q       <= 1'b1;
            stop_q        <= 1'b1;
            sec_cnt       <= '0;
            step_cnt      <= '0;
            o_half_w      <= MAX_W;
            o_half_h      <= MAX_H;
            o_seconds     <= '0;
            o_round       <= '0;
            o_score       <= '0;
            o_best        <= '0;
            o_score_valid <= 1'b0;
            area          <= '0;
            penalty       <= '0;
        end else begin
            start_q       <= i_start;
            stop_q        <= i_stop;
            o_score_valid <= 1'b0;
            case (state)
                RUN: begin
                    sec_cnt   <= sec_wrap ? '0 : sec_cnt + 1'b1;
                    step_cnt  <= step_tick ? '0 : step_cnt + 1'b1;
                    o_seconds <= seconds_next;
                    // Exit takes priority: the frame keeps its pre-tick value.
                    if (step_tick && !run_exit) begin
                        o_half_w <= shrink(o_half_w, i_rand, TGT_W, MAX_W);
                        o_half_h <= shrink(o_half_h, i_rand, TGT_H, MAX_H);
                    end
                end
                CALC1: begin
                    area    <= (SW'(o_half_w) << 1) * (SW'(o_half_h) << 1);
                    penalty <= PEN * SW'(o_seconds);
                end
                CALC2: begin
                    o_score       <= score_calc;
                    o_score_valid <= 1'b1;
                    if (score_calc > o_best)
                        o_best <= score_calc;
                end
                default: ;
            endcase
            if (round_start) begin
                sec_cnt   <= '0;
                step_cnt  <= '0;
                o_seconds <= '0;
                o_half_w  <= MAX_W;
                o_half_h  <= MAX_H;
                o_round   <= (state == DONE) ? 4'd1 : o_round + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_game_round_ctrl.sv
// Directed, table-driven bench for m_game_round_ctrl with hand-computed
// expectations; a second instance uses a large per-second penalty.
module tb_m_game_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [3:0]  rnd_in;

    logic [10:0] half_w, half_h, half_w2, half_h2;
    logic [7:0]  seconds, seconds2;
    logic [3:0]  round, round2;
    logic [31:0] score, best, score2, best2;
    logic        valid, running, over, valid2, running2, over2;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    m_game_round_ctrl #(
        .CLK_HZ(10), .STEP_DIV(4), .ROUND_SEC(3), .ROUNDS(2), .W(11),
        .MAX_HALF_W(40), .MAX_HALF_H(30), .TGT_HALF_W(2), .TGT_HALF_H(1),
        .SW(32), .SCORE_BASE(500000), .SEC_PENALTY(15000)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .i_rand(rnd_in),
        .o_half_w(half_w), .o_half_h(half_h), .o_seconds(seconds), .o_round(round),
        .o_score(score), .o_best(best), .o_score_valid(valid),
        .o_running(running), .o_game_over(over)
    );

    m_game_round_ctrl #(
        .CLK_HZ(10), .STEP_DIV(4), .ROUND_SEC(3), .ROUNDS(2), .W(11),
        .MAX_HALF_W(40), .MAX_HALF_H(30), .TGT_HALF_W(2), .TGT_HALF_H(1),
        .SW(32), .SCORE_BASE(500000), .SEC_PENALTY(200000)
    ) dut2 (
        .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .i_rand(rnd_in),
        .o_half_w(half_w2), .o_half_h(half_h2), .o_seconds(seconds2), .o_round(round2),
        .o_score(score2), .o_best(best2), .o_score_valid(valid2),
        .o_running(running2), .o_game_over(over2)
    );

    typedef struct {
        logic        start;
        logic        stop;
        int unsigned n;
        logic [10:0] w;
        logic [10:0] h;
        logic [7:0]  sec;
        logic [3:0]  rnd;
        logic [31:0] score;
        logic [31:0] best;
        logic [31:0] score2;
        logic [31:0] best2;
        logic        valid;
        logic        running;
        logic        over;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic st, input logic sp, input int unsigned n,
                                input int unsigned w, input int unsigned h,
                                input int unsigned sec, input int unsigned rnd,
                                input int unsigned sc, input int unsigned bs,
                                input int unsigned sc2, input int unsigned bs2,
                                input logic vl, input logic rn, input logic ov);
        vec_t v;
        v.start = st;  v.stop = sp;  v.n = n;
        v.w = 11'(w);  v.h = 11'(h); v.sec = 8'(sec); v.rnd = 4'(rnd);
        v.score = sc;  v.best = bs;  v.score2 = sc2;  v.best2 = bs2;
        v.valid = vl;  v.running = rn; v.over = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " half_w"},  64'(half_w),  64'd40);
        chk({tag, " half_h"},  64'(half_h),  64'd30);
        chk({tag, " seconds"}, 64'(seconds), 64'd0);
        chk({tag, " round"},   64'(round),   64'd0);
        chk({tag, " score"},   64'(score),   64'd0);
        chk({tag, " best"},    64'(best),    64'd0);
        chk({tag, " valid"},   64'(valid),   64'd0);
        chk({tag, " running"}, 64'(running), 64'd0);
        chk({tag, " over"},    64'(over),    64'd0);
        chk({tag, " best2"},   64'(best2),   64'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              st sp  n   w   h sec rd  score   best    score2  best2  vl rn ov
        vecs[0]  = mk(1, 0, 1,  40, 30, 0, 1, 0,      0,      0,      0,      0, 1, 0);
        vecs[1]  = mk(0, 0, 3,  40, 30, 0, 1, 0,      0,      0,      0,      0, 1, 0);
        vecs[2]  = mk(0, 0, 1,  35, 25, 0, 1, 0,      0,      0,      0,      0, 1, 0);
        vecs[3]  = mk(0, 1, 1,  35, 25, 0, 1, 0,      0,      0,      0,      0, 0, 0);
        vecs[4]  = mk(0, 0, 1,  35, 25, 0, 1, 0,      0,      0,      0,      0, 0, 0);
        vecs[5]  = mk(0, 0, 1,  35, 25, 0, 1, 496500, 496500, 496500, 496500, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1,  35, 25, 0, 1, 496500, 496500, 496500, 496500, 0, 0, 0);
        vecs[7]  = mk(0, 1, 2,  35, 25, 0, 1, 496500, 496500, 496500, 496500, 0, 0, 0);
        vecs[8]  = mk(1, 0, 1,  40, 30, 0, 2, 496500, 496500, 496500, 496500, 0, 1, 0);
        vecs[9]  = mk(0, 0, 29,  5, 30, 2, 2, 496500, 496500, 496500, 496500, 0, 1, 0);
        vecs[10] = mk(0, 0, 1,   5, 30, 3, 2, 496500, 496500, 496500, 496500, 0, 0, 0);
        vecs[11] = mk(0, 0, 2,   5, 30, 3, 2, 454400, 496500, 0,      496500, 1, 0, 1);
        vecs[12] = mk(0, 1, 2,   5, 30, 3, 2, 454400, 496500, 0,      496500, 0, 0, 1);
        vecs[13] = mk(1, 0, 1,  40, 30, 0, 1, 454400, 496500, 0,      496500, 0, 1, 0);
        vecs[14] = mk(0, 0, 3,  40, 30, 0, 1, 454400, 496500, 0,      496500, 0, 1, 0);
        vecs[15] = mk(0, 1, 1,  40, 30, 0, 1, 454400, 496500, 0,      496500, 0, 0, 0);
        vecs[16] = mk(0, 0, 2,  40, 30, 0, 1, 495200, 496500, 495200, 496500, 1, 0, 0);

        // Reset with start held high, then release while still held.
        rst = 1'b1; start = 1'b1; stop = 1'b0; rnd_in = 4'd5;
        #1;
        chk_reset("reset");
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("held_start round",   64'(round),   64'd0);
        chk("held_start running", 64'(running), 64'd0);
        start = 1'b0;
        cyc();

        for (int i = 0; i < 17; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            cyc();
            start = 1'b0;
            stop  = 1'b0;
            for (int j = 1; j < int'(vecs[i].n); j++) cyc();
            chk($sformatf("row%0d half_w", i),  64'(half_w),  64'(vecs[i].w));
            chk($sformatf("row%0d half_h", i),  64'(half_h),  64'(vecs[i].h));
            chk($sformatf("row%0d seconds", i), 64'(seconds), 64'(vecs[i].sec));
            chk($sformatf("row%0d round", i),   64'(round),   64'(vecs[i].rnd));
            chk($sformatf("row%0d score", i),   64'(score),   64'(vecs[i].score));
            chk($sformatf("row%0d best", i),    64'(best),    64'(vecs[i].best));
            chk($sformatf("row%0d score2", i),  64'(score2),  64'(vecs[i].score2));
            chk($sformatf("row%0d best2", i),   64'(best2),   64'(vecs[i].best2));
            chk($sformatf("row%0d valid", i),   64'(valid),   64'(vecs[i].valid));
            chk($sformatf("row%0d running", i), 64'(running), 64'(vecs[i].running));
            chk($sformatf("row%0d over", i),    64'(over),    64'(vecs[i].over));
        end

        // Reset in the middle of round 2, between clock edges.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int j = 0; j < 4; j++) cyc();
        chk("midrun round",   64'(round),   64'd2);
        chk("midrun half_w",  64'(half_w),  64'd35);
        chk("midrun running", 64'(running), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_reset");
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart round",   64'(round),   64'd1);
        chk("restart running", 64'(running), 64'd1);
        chk("restart best",    64'(best),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_game_round_ctrl.md
Name: m_game_round_ctrl

Overview:
- Parametrised multi-round controller for the shrinking-frame target game.
- Owns the per-round second timer, the LFSR-driven frame shrink and the stop/timeout capture.
- Computes a clamped per-round score and tracks the best score across rounds.
- Outputs drive the rectangle drawers (frame half-size), the 7-seg score display and status LEDs; the VGA path is unchanged.

Parameters:
CLK_HZ, 40000000, cycles per game second
STEP_DIV, 500000, cycles per frame-shrink step
ROUND_SEC, 30, round timeout in seconds (1..255)
ROUNDS, 3, rounds per game (1..15)
W, 11, coordinate width
MAX_HALF_W, 400, frame half-width at round start
MAX_HALF_H, 300, frame half-height at round start
TGT_HALF_W, 20, target half-width
TGT_HALF_H, 15, target half-height
SW, 32, score width
SCORE_BASE, 500000, score before deductions
SEC_PENALTY, 15000, deduction per elapsed second

Ports:
clk  in  1  game clock
rst  in  1  asynchronous, active-high reset
i_start  in  1  start/next-round button, level
i_stop  in  1  stop button, level
i_rand  in  4  LFSR value, sampled at each step tick
o_half_w  out  W  current frame half-width
o_half_h  out  W  current frame half-height
o_seconds  out  8  elapsed seconds in the current round
o_round  out  4  current round number, 1-based; 0 before the first start
o_score  out  SW  last round score
o_best  out  SW  maximum score since reset
o_score_valid  out  1  one-cycle pulse when o_score updates
o_running  out  1  high while in RUN
o_game_over  out  1  high in DONE

Behaviour:
- Reset values: state IDLE; o_half_w=MAX_HALF_W; o_half_h=MAX_HALF_H; all other outputs 0; prescalers 0. Edge-detect registers reset to 1, so a button held through reset release is not an edge.
- Edges: rising edge = input high now and registered previous value low. Only rising edges act.
- States: IDLE, RUN, CALC1, CALC2, HOLD, DONE.
- IDLE/HOLD + start edge at clock edge k: from edge k, state is RUN and o_running=1. Round increments. o_seconds, prescalers and frame are reset to max/0.
- DONE + start edge: enters RUN with round=1 and o_game_over=0; o_best is kept.
- RUN, second prescaler: counts 0..CLK_HZ-1. On wrap, o_seconds increments, saturating at 255.
- RUN, step prescaler: counts 0..STEP_DIV-1. The tick occurs on the cycle the count equals STEP_DIV-1.
- Step tick, width: if o_half_w > TGT_HALF_W, o_half_w <= o_half_w - i_rand, saturating at 0; otherwise o_half_w <= MAX_HALF_W.
- Step tick, height: same rule, applied independently, using TGT_HALF_H and MAX_HALF_H.
- RUN exit: a stop edge, or o_seconds becoming ROUND_SEC, moves RUN to CALC1 on that edge and o_running drops.
- Exit priority: the exit transition wins over a same-cycle step tick. The frame keeps its pre-tick value; o_seconds takes its incremented value.
- CALC1: registers area = (2·w)·(2·h) and penalty = SEC_PENALTY·o_seconds, at full SW width.
- CALC2: o_score = max(0, SCORE_BASE - area - penalty), using signed arithmetic with one guard bit. o_score_valid=1 for this cycle only. o_best updates if o_score > o_best.
- CALC2 exit: goes to DONE with o_game_over=1 if round==ROUNDS, else to HOLD.
- Latency: stop edge at edge k gives o_score_valid high after edge k+2.
- Ignored events: start edges in RUN/CALC1/CALC2; stop edges outside RUN.
- HOLD/DONE: frame, seconds and score are frozen.
- Reset mid-round: everything returns to reset values at once, including o_best.

Test Plan:
Shared bench settings: CLK_HZ=10, STEP_DIV=4, ROUND_SEC=3, ROUNDS=2, MAX 40/30, TGT 2/1, i_rand=5.
1. Start, then stop edge 1 cycle after the first step tick -> w=35, h=25, seconds=0. Score=500000-3500=496500; valid pulse exactly 2 cycles after the stop edge; best=496500.
2. Start and no stop -> timeout at 30 cycles after 7 ticks; w=5, h=30 (h wraps via 0). Score=500000-600-45000=454400. Best stays 496500; o_game_over=1 after round 2.
3. Stop edge on the same cycle as a step tick -> frame holds its pre-tick value.
4. Stop ignored in HOLD and DONE.
5. Start held high across reset release -> no start.
6. SEC_PENALTY=200000, timeout -> o_score=0 (clamped), o_best unchanged.
7. Assert rst mid-RUN -> all outputs return to reset values asynchronously. Next start edge -> round=1.
